mem_req_ctrl: RTL and testbench

//  MEM-stage load/store controller between the EX/MEM pipeline register and the data-memory port.

---
 rtl/mem_req_ctrl_pkg.sv | 33 +++
 rtl/mem_width_decode.sv | 44 ++++
 rtl/mem_req_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the MEM-stage load/store controller: memory op encoding,
// controller state encoding and the op-to-width helper.
package mem_req_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_D  = 3'd1,
    MEM_W  = 3'd2,
    MEM_H  = 3'd3,
    MEM_B  = 3'd4,
    MEM_UW = 3'd5,
    MEM_UH = 3'd6,
    MEM_UB = 3'd7
  } mem_op_enum;

  typedef logic [1:0] mem_ctrl_state_t;

  localparam mem_ctrl_state_t ST_IDLE = 2'd0;
  localparam mem_ctrl_state_t ST_REQ  = 2'd1;
  localparam mem_ctrl_state_t ST_WAIT = 2'd2;
  localparam mem_ctrl_state_t ST_DONE = 2'd3;

  function automatic logic [3:0] op_width(input mem_op_enum op);
    case (op)
      MEM_D:          op_width = 4'd8;
      MEM_W, MEM_UW:  op_width = 4'd4;
      MEM_H, MEM_UH:  op_width = 4'd2;
      MEM_B, MEM_UB:  op_width = 4'd1;
      default:        op_width = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_width_decode.sv
// Combinational decode of a memory op and byte offset into access width,
// byte-write mask and misalignment flag.
module mem_width_decode
  import mem_req_ctrl_pkg::*;
(
  input  mem_op_enum  mem_op,
  input  logic [2:0]  addr_lo,
  output logic [3:0]  width,
  output logic [7:0]  wmask,
  output logic        misalign
);

  logic [7:0] mask_base;

  always_comb begin
    width     = op_width(mem_op);
    mask_base = 8'h00;
    misalign  = 1'b0;
    case (width)
      4'd8: begin
        mask_base = 8'hFF;
        misalign  = (addr_lo != 3'd0);
      end
      4'd4: begin
        mask_base = 8'h0F;
        misalign  = (addr_lo[1:0] != 2'd0);
      end
      4'd2: begin
        mask_base = 8'h03;
        misalign  = addr_lo[0];
      end
      4'd1: begin
        mask_base = 8'h01;
        misalign  = 1'b0;
      end
      default: begin
        mask_base = 8'h00;
        misalign  = 1'b0;
      end
    endcase
    wmask = mask_base << addr_lo;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage load/store controller: captures one access from EX/MEM, issues it to
// data memory over valid/ready, waits for load data with a timeout, and pulses completion.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned RESP_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_re,
  input  logic              in_we,
  input  mem_op_enum        in_mem_op,
  input  logic [ADDR_W-1:0] in_alu_res,
  input  logic [63:0]       in_rs2,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_rdata,
  output logic              out_valid,
  output logic [63:0]       out_read_data,
  output logic [3:0]        out_width,
  output mem_op_enum        out_mem_op,
  output logic [ADDR_W-1:0] out_alu_res,
  output logic              out_misalign,
  output logic              out_timeout
);

  localparam int unsigned CNT_W   = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1;

  mem_ctrl_state_t   state_q, state_d;
  mem_op_enum        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       rs2_q, rs2_d;
  logic              wen_q, wen_d;
  logic [3:0]        width_q, width_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0] dec_width;
  logic [7:0] dec_wmask;
  logic       dec_misalign;
  logic       access;

  mem_width_decode u_width_decode (
    .mem_op   (in_mem_op),
    .addr_lo  (in_alu_res[2:0]),
    .width    (dec_width),
    .wmask    (dec_wmask),
    .misalign (dec_misalign)
  );

  assign access = in_valid & (in_re | in_we) & (in_mem_op != MEM_NO);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rs2_d      = rs2_q;
    wen_d      = wen_q;
    width_d    = width_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          // in_we alone decides the direction, so a load+store pair acts as a store
          op_d       = in_mem_op;
          addr_d     = in_alu_res;
          rs2_d      = in_rs2;
          wen_d      = in_we;
          width_d    = dec_width;
          wmask_d    = in_we ? dec_wmask : 8'h00;
          rdata_d    = 64'd0;
          misalign_d = dec_misalign;
          timeout_d  = 1'b0;
          state_d    = dec_misalign ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = wen_q ? ST_DONE : ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else if ((RESP_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= MEM_NO;
      addr_q     <= '0;
      rs2_q      <= '0;
      wen_q      <= 1'b0;
      width_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rs2_q      <= rs2_d;
      wen_q      <= wen_d;
      width_q    <= width_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  // The completion cycle releases the pipeline so the finished instruction can advance.
  assign stall = (state_q == ST_REQ) | (state_q == ST_WAIT) | ((state_q == ST_IDLE) & access);

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wen       = wen_q;
  assign mem_wdata     = rs2_q << {addr_q[2:0], 3'b000};
  assign mem_wmask     = wmask_q;

  assign out_valid     = (state_q == ST_DONE);
  assign out_read_data = rdata_q;
  assign out_width     = width_q;
  assign out_mem_op    = op_q;
  assign out_alu_res   = addr_q;
  assign out_misalign  = misalign_q;
  assign out_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: the driver predicts requests and completions
// from the access rules, and a negedge monitor compares whatever the DUT presents.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_re, in_we;
  mem_op_enum  in_mem_op;
  logic [63:0] in_alu_res, in_rs2;
  logic        stall, mem_req_valid, mem_req_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, out_read_data, out_alu_res;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid, out_valid, out_misalign, out_timeout;
  logic [3:0]  out_width;
  mem_op_enum  out_mem_op;

  mem_req_ctrl #(.ADDR_W(64), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_re(in_re), .in_we(in_we), .in_mem_op(in_mem_op),
    .in_alu_res(in_alu_res), .in_rs2(in_rs2),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_read_data(out_read_data), .out_width(out_width),
    .out_mem_op(out_mem_op), .out_alu_res(out_alu_res),
    .out_misalign(out_misalign), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    int          cyc;
    logic [63:0] rdata;
    int          width;
    mem_op_enum  op;
    logic [63:0] alu;
    logic        mis;
    logic        to;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_width(input mem_op_enum op);
    case (op)
      MEM_D:         return 8;
      MEM_W, MEM_UW: return 4;
      MEM_H, MEM_UH: return 2;
      MEM_B, MEM_UB: return 1;
      default:       return 0;
    endcase
  endfunction

  // Monitor: compares every presented request beat and completion pulse.
  always @(negedge clk) begin : monitor
    req_t r;
    cmp_t e;
    if (!rst) begin
      check("stall", 64'(stall), 64'((cyc >= start_cyc) && (cyc < done_cyc)));
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 64'(mem_req_valid), 64'd0);
        end else begin
          r = req_q[0];
          check("mem_addr", mem_addr, r.addr);
          check("mem_wen", 64'(mem_wen), 64'(r.wen));
          check("mem_wdata", mem_wdata, r.wdata);
          check("mem_wmask", 64'(mem_wmask), 64'(r.wmask));
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (out_valid) begin
        if (cmp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = cmp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("out_read_data", out_read_data, e.rdata);
          check("out_width", 64'(out_width), 64'(e.width));
          check("out_mem_op", 64'(out_mem_op), 64'(e.op));
          check("out_alu_res", out_alu_res, e.alu);
          check("out_misalign", 64'(out_misalign), 64'(e.mis));
          check("out_timeout", 64'(out_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_re = 1'b0; in_we = 1'b0; in_mem_op = MEM_NO;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  // k: REQ cycles with ready low; d: WAIT cycles before the response pulse.
  task automatic run_txn(input logic re, input logic we, input mem_op_enum op,
                         input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [63:0] rdata, input int k, input int d);
    int w, off, lat, n, guard;
    logic mis, ld_ok;
    cmp_t e;
    req_t r;
    w   = ref_width(op);
    off = int'(addr % 8);
    mis = ((addr % 64'(w)) != 0);
    ld_ok = !mis && !we && (d < TO);
    n   = cyc;
    in_valid = 1'b1; in_re = re; in_we = we; in_mem_op = op;
    in_alu_res = addr; in_rs2 = rs2;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (!mis) begin
      r.addr  = addr - 64'(off);
      r.wen   = we;
      r.wdata = rs2 << (8 * off);
      r.wmask = we ? 8'(((1 << w) - 1) << off) : 8'h00;
      req_q.push_back(r);
    end
    if (mis)       lat = 1;
    else if (we)   lat = 2 + k;
    else if (ld_ok) lat = 3 + k + d;
    else           lat = 2 + k + TO;
    e.cyc = n + lat; e.rdata = ld_ok ? rdata : 64'd0; e.width = w; e.op = op;
    e.alu = addr; e.mis = mis; e.to = !mis && !we && (d >= TO);
    cmp_q.push_back(e);
    start_cyc = n; done_cyc = n + lat;
    tick();
    in_valid = 1'b0;
    in_alu_res = {$urandom, $urandom};
    if (!mis) begin
      repeat (k) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      if (!we) begin
        repeat (d) tick();
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
      end
    end
    guard = 0;
    while (cmp_q.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    if (cmp_q.size() != 0) begin
      check("completion_bound", 64'(cmp_q.size()), 64'd0);
      cmp_q.delete();
    end
    if (req_q.size() != 0) begin
      check("request_accept", 64'(req_q.size()), 64'd0);
      req_q.delete();
    end
    check("held_read_data", out_read_data, e.rdata);
    check("held_alu_res", out_alu_res, e.alu);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) begin
      in_valid = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        in_re = 1'b0; in_we = 1'b0; in_mem_op = mem_op_enum'($urandom_range(0, 7));
      end else begin
        in_re = 1'($urandom); in_we = 1'($urandom); in_mem_op = MEM_NO;
      end
      mem_req_ready = 1'($urandom); mem_resp_valid = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
  endtask

  task automatic reset_in_wait();
    int n;
    req_t r;
    n = cyc;
    in_valid = 1'b1; in_re = 1'b1; in_we = 1'b0; in_mem_op = MEM_D;
    in_alu_res = 64'h0000_0000_0000_3008; in_rs2 = 64'd0;
    r.addr = 64'h3008; r.wen = 1'b0; r.wdata = 64'd0; r.wmask = 8'h00;
    req_q.push_back(r);
    start_cyc = n; done_cyc = n + 1000;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_alu_res", out_alu_res, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    tick();
    done_cyc = cyc;
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    repeat (4) begin
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_read_data", out_read_data, 64'd0);
      tick();
    end
    req_q.delete();
  endtask

  initial begin
    int w;
    logic [63:0] a;
    mem_op_enum op;
    logic re, we;
    rst = 1'b1;
    in_alu_res = 64'd0; in_rs2 = 64'd0; mem_rdata = 64'd0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_req_valid", 64'(mem_req_valid), 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    check("reset_mem_wen", 64'(mem_wen), 64'd0);
    check("reset_mem_wdata", mem_wdata, 64'd0);
    check("reset_mem_wmask", 64'(mem_wmask), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_read_data", out_read_data, 64'd0);
    check("reset_out_width", 64'(out_width), 64'd0);
    check("reset_out_mem_op", 64'(out_mem_op), 64'd0);
    check("reset_out_misalign", 64'(out_misalign), 64'd0);
    check("reset_out_timeout", 64'(out_timeout), 64'd0);
    rst = 1'b0;
    tick();

    run_txn(1'b0, 1'b1, MEM_W,  64'h1004, 64'hDEAD_BEEF, 64'd0, 0, 0);
    gap();
    run_txn(1'b1, 1'b0, MEM_B,  64'h2003, 64'd0, 64'h1122_3344_5566_7788, 0, 3);
    gap();
    run_txn(1'b1, 1'b0, MEM_H,  64'h0001, 64'd0, 64'd0, 0, 0);
    run_txn(1'b1, 1'b0, MEM_D,  64'h4000, 64'h55AA_55AA_55AA_55AA, 64'h0BAD_CAFE_0000_0001, 5, 0);
    run_txn(1'b1, 1'b0, MEM_W,  64'h5008, 64'd0, 64'hFFFF_0000_FFFF_0000, 0, 10);
    run_txn(1'b1, 1'b1, MEM_UH, 64'h6006, 64'h0000_0000_0000_BEEF, 64'd0, 1, 0);
    reset_in_wait();

    repeat (200) begin
      op = mem_op_enum'($urandom_range(1, 7));
      w  = ref_width(op);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(w - 1);
      case ($urandom_range(0, 2))
        0:       begin re = 1'b1; we = 1'b0; end
        1:       begin re = 1'b0; we = 1'b1; end
        default: begin re = 1'b1; we = 1'b1; end
      endcase
      run_txn(re, we, op, a, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 5));
      gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
